pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures a digital PWM stream such as a switch gate drive, reporting its period and high time in clock cycles. It sits beside the emulated plant on the emulation clock, watches a `PWM`-generated control bit (or an external one), and exposes registered measurements that are easy to probe. It flags a stuck-high or stuck-low input when no rising edge arrives within a timeout. It reports raw counts only; duty-cycle division happens downstream.

## Interface
- `CNT_WIDTH`, default 16: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, default 2: flop stages on `pwm_in` before edge detection; legal range 1..4.
- `TIMEOUT`, default 2**CNT_WIDTH-1: maximum period count before the stuck condition; legal range 2..2**CNT_WIDTH-1.
- `clk` input 1: emulation clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: measurement enable, sampled synchronously.
- `pwm_in` input 1: PWM signal under measurement; may be asynchronous to `clk`.
- `meas_period` output CNT_WIDTH: cycles from one rising edge to the next.
- `meas_high` output CNT_WIDTH: cycles `pwm_in` stayed high within that period.
- `meas_valid` output 1: one-cycle strobe when `meas_period`/`meas_high` update.
- `stuck` output 1: level; the input saw no rising edge within TIMEOUT cycles.
- `stuck_level` output 1: synchronized input level captured when `stuck` was set.

## Operation
- `s` is the synchronizer output. `s_d` is `s` delayed one cycle. `rise = s & ~s_d` and `fall = ~s & s_d`.
- Internal counters `pc` (period) and `hc` (high) are CNT_WIDTH bits wide.

States:
- **IDLE** (reset state):
  - On `rise`: `pc <= 1`, `hc <= 1`, go to HIGH.
  - Nothing is reported, because the first partial period is discarded.
- **HIGH**:
  - On `fall`: `pc <= pc+1`, `hc` holds, go to LOW.
  - Otherwise, when `s` is high: `pc <= pc+1`, `hc <= hc+1`.
- **LOW**:
  - On `rise`: `meas_period <= pc`, `meas_high <= hc`, `meas_valid <= 1`, `pc <= 1`, `hc <= 1`, go to HIGH.
  - Otherwise: `pc <= pc+1`.
- **STUCK**:
  - Counters hold.
  - On `rise`: clear `stuck`, `pc <= 1`, `hc <= 1`, go to HIGH, with no `meas_valid`.

Timeout and enable:
- **Timeout:** in HIGH or LOW, if `pc == TIMEOUT` and there is no `rise` this cycle, set `stuck <= 1` and `stuck_level <= s`, then go to STUCK. A `rise` in the same cycle wins, so the largest reportable `meas_period` is TIMEOUT.
- **`en` = 0:** state goes to IDLE, `pc`/`hc` clear to 0, `stuck` clears, `meas_valid` is 0, and `meas_period`/`meas_high` hold their last value. The synchronizer and `s_d` keep running, so a level already high when `en` rises does not count as a `rise`.

Invariants and arithmetic:
- `hc <= pc` always holds.
- A reported period of H high plus L low cycles gives `meas_period = H+L` and `meas_high = H`.
- The minimum legal waveform is H=1, L=1.
- Counters never wrap, because the timeout fires first.

## Timing
- **Reset values:** `meas_period`=0, `meas_high`=0, `meas_valid`=0, `stuck`=0, `stuck_level`=0, state IDLE, synchronizer flops 0.
- **`rise` detection:** `rise` is true in the cycle when `s` first reads 1. That is `SYNC_STAGES` cycles after `pwm_in` is first sampled high.
- **Measurement latency:** `meas_valid` is high for exactly the one cycle following the `rise` cycle. `meas_period`/`meas_high` change on the same edge and hold until the next update.
- **Stuck latency:** `stuck` rises on the edge following the cycle where `pc == TIMEOUT`.
- **Reset mid-operation:** asserting `rst_n` low clears everything immediately. The first report after release needs two rising edges.

## Test plan
- **Periodic wave:** square wave 10 high / 10 low for 5 periods → first `meas_valid` on the second `rise`; every strobe reports period 20, high 10; strobes exactly 20 cycles apart.
- **Minimum waveform:** 1 high / 1 low alternating → period 2, high 1 on every strobe; `stuck` never set.
- **Duty change:** switch from 3/7 to 8/2 mid-stream → reports 10/3 then 10/8, with no intermediate mixed value; `hc <= pc` throughout.
- **Timeout:** TIMEOUT=50, hold `pwm_in` high after a `rise` → `stuck`=1 and `stuck_level`=1 on the edge after `pc` reaches 50; no `meas_valid`. A later 4/4 wave clears `stuck`, and the next report after two rises is 8/4.
- **Reset mid-operation:** assert `rst_n` low while in LOW with `pc`=6 → all outputs 0 asynchronously. After release with a 5/5 wave, the first strobe is on the second `rise` and reports 10/5.
- **Enable gating:** drop `en` for 3 cycles mid-period with `pwm_in` high → no strobe, last measurement held. After `en` returns, the first strobe comes only after two fresh rising edges.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM period / high-time meter: synchronizes a possibly asynchronous PWM bit,
// counts cycles between rising edges and flags a stuck input on timeout.
module pwm_capture #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = (2 ** CNT_WIDTH) - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] meas_period,
  output logic [CNT_WIDTH-1:0] meas_high,
  output logic                 meas_valid,
  output logic                 stuck,
  output logic                 stuck_level
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_STUCK
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] LP_ONE     = CNT_WIDTH'(1);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_WIDTH-1:0]   r_pc;
  logic [CNT_WIDTH-1:0]   r_hc;

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_timeout;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_timeout = (r_pc == LP_TIMEOUT) & ~w_rise;

  // The synchronizer and edge history run regardless of en, so a level that is
  // already high when measurement is enabled is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_sync[0] <= pwm_in;
      r_s_d     <= w_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_hc        <= '0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides it,
      // which turns meas_valid into a one-cycle strobe without extra logic.
      meas_valid <= 1'b0;
      if (!en) begin
        r_state <= ST_IDLE;
        r_pc    <= '0;
        r_hc    <= '0;
        stuck   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // The first partial period is discarded: start counting, report nothing.
            if (w_rise) begin
              r_pc    <= LP_ONE;
              r_hc    <= LP_ONE;
              r_state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (w_timeout) begin
              stuck       <= 1'b1;
              stuck_level <= w_s;
              r_state     <= ST_STUCK;
            end else if (w_fall) begin
              r_pc    <= r_pc + LP_ONE;
              r_state <= ST_LOW;
            end else if (w_s) begin
              r_pc <= r_pc + LP_ONE;
              r_hc <= r_hc + LP_ONE;
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              meas_period <= r_pc;
              meas_high   <= r_hc;
              meas_valid  <= 1'b1;
              r_pc        <= LP_ONE;
              r_hc        <= LP_ONE;
              r_state     <= ST_HIGH;
            end else if (w_timeout) begin
              stuck       <= 1'b1;
              stuck_level <= w_s;
              r_state     <= ST_STUCK;
            end else begin
              r_pc <= r_pc + LP_ONE;
            end
          end
          ST_STUCK: begin
            if (w_rise) begin
              stuck   <= 1'b0;
              r_pc    <= LP_ONE;
              r_hc    <= LP_ONE;
              r_state <= ST_HIGH;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture: periodic, minimum, duty change,
// timeout, asynchronous reset and enable gating scenarios.
module tb_pwm_capture;

  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          pwm_in;
  logic [CW-1:0] meas_period;
  logic [CW-1:0] meas_high;
  logic          meas_valid;
  logic          stuck;
  logic          stuck_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int inv_bad = 0;
  int stuck_seen = 0;
  int q_per[$];
  int q_high[$];
  int q_cyc[$];
  int c0;
  int bad;
  int exp_h[6] = '{3, 3, 3, 8, 8, 8};

  pwm_capture #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(2),
    .TIMEOUT    (50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .meas_period(meas_period),
    .meas_high  (meas_high),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log and invariant watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (meas_valid) begin
      q_per.push_back(int'(meas_period));
      q_high.push_back(int'(meas_high));
      q_cyc.push_back(cyc);
    end
    if (dut.r_hc > dut.r_pc) inv_bad++;
    if (stuck) stuck_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      step(h);
      pwm_in = 1'b0;
      step(l);
    end
  endtask

  task automatic clear_log();
    q_per.delete();
    q_high.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    clear_log();
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b0;
    step(3);
    check("rst_period", 32'(meas_period), 0);
    check("rst_high", 32'(meas_high), 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_stuck", 32'(stuck), 0);
    check("rst_stuck_level", 32'(stuck_level), 0);
    rst_n = 1'b1;
    step(4);
    check("idle_valid", 32'(meas_valid), 0);

    // Periodic 10/10 wave, five full periods plus a closing rise.
    do_reset();
    c0 = cyc;
    wave(10, 10, 5);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(2);
    check("t1_count", q_per.size(), 5);
    for (int i = 0; i < q_per.size(); i++) begin
      check($sformatf("t1_period%0d", i), q_per[i], 20);
      check($sformatf("t1_high%0d", i), q_high[i], 10);
      if (i == 0) check("t1_first_cyc", q_cyc[0], c0 + 23);
      else check($sformatf("t1_gap%0d", i), q_cyc[i] - q_cyc[i-1], 20);
    end

    // Minimum 1/1 waveform.
    do_reset();
    stuck_seen = 0;
    wave(1, 1, 20);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(2);
    check("t2_count", q_per.size(), 20);
    bad = 0;
    for (int i = 0; i < q_per.size(); i++) begin
      if (q_per[i] != 2 || q_high[i] != 1) bad++;
    end
    check("t2_bad_reports", bad, 0);
    check("t2_stuck_seen", stuck_seen, 0);

    // Duty change 3/7 -> 8/2.
    do_reset();
    inv_bad = 0;
    wave(3, 7, 3);
    wave(8, 2, 3);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(2);
    check("t3_count", q_per.size(), 6);
    for (int i = 0; i < q_per.size() && i < 6; i++) begin
      check($sformatf("t3_period%0d", i), q_per[i], 10);
      check($sformatf("t3_high%0d", i), q_high[i], exp_h[i]);
    end
    check("t3_hc_le_pc", inv_bad, 0);

    // Timeout at 50 with the input held high.
    do_reset();
    pwm_in = 1'b1;
    step(52);
    check("t4_stuck_before", 32'(stuck), 0);
    step(1);
    check("t4_stuck", 32'(stuck), 1);
    check("t4_stuck_level", 32'(stuck_level), 1);
    check("t4_no_strobe", q_per.size(), 0);
    pwm_in = 1'b0;
    step(4);
    check("t4_stuck_hold", 32'(stuck), 1);
    wave(4, 4, 3);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(2);
    check("t4_stuck_cleared", 32'(stuck), 0);
    check("t4_count", q_per.size(), 3);
    if (q_per.size() > 0) begin
      check("t4_period", q_per[0], 8);
      check("t4_high", q_high[0], 4);
    end

    // Asynchronous reset while in LOW with pc = 6.
    do_reset();
    wave(5, 5, 2);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(3);
    check("t5_pre_period", 32'(meas_period), 10);
    check("t5_pre_pc", 32'(dut.r_pc), 6);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_period", 32'(meas_period), 0);
    check("t5_async_high", 32'(meas_high), 0);
    check("t5_async_valid", 32'(meas_valid), 0);
    check("t5_async_stuck", 32'(stuck), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    clear_log();
    c0 = cyc;
    wave(5, 5, 3);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(2);
    check("t5_count", q_per.size(), 3);
    if (q_per.size() > 0) begin
      check("t5_period", q_per[0], 10);
      check("t5_high", q_high[0], 5);
      check("t5_first_cyc", q_cyc[0], c0 + 13);
    end

    // Enable dropped for 3 cycles mid-period with the input high.
    do_reset();
    wave(6, 6, 2);
    pwm_in = 1'b1;
    step(4);
    check("t6_pre_count", q_per.size(), 2);
    clear_log();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("t6_dis_valid%0d", i), 32'(meas_valid), 0);
    end
    check("t6_hold_period", 32'(meas_period), 12);
    check("t6_hold_high", 32'(meas_high), 6);
    en = 1'b1;
    step(3);
    pwm_in = 1'b0;
    step(6);
    c0 = cyc;
    wave(6, 6, 2);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(2);
    check("t6_count", q_per.size(), 2);
    for (int i = 0; i < q_per.size(); i++) begin
      check($sformatf("t6_period%0d", i), q_per[i], 12);
      check($sformatf("t6_high%0d", i), q_high[i], 6);
    end
    if (q_cyc.size() > 0) check("t6_first_cyc", q_cyc[0], c0 + 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
